// File: rtl/math_hit_processor_pkg.sv
// Shared types and helpers for the math hit processor game logic.
package math_hit_processor_pkg;

  // Game controller states; encoding is visible on the HUD/debug port.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_A    = 3'd1,
    ST_WAIT_OP   = 3'd2,
    ST_WAIT_B    = 3'd3,
    ST_EVAL      = 3'd4,
    ST_RESPAWN   = 3'd5,
    ST_GAME_OVER = 3'd6
  } state_t;

  // Operator picked up from the operand objects.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Isolates the lowest set bit of a hit vector (one-hot result, zero if none set).
  function automatic logic [31:0] lowest_set_onehot(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/math_hit_processor_alu.sv
// Combinational evaluator for "A op B" compared against the round target.
module expr_alu
  import math_hit_processor_pkg::*;
#(
  parameter int VAL_W = 4,
  parameter int RES_W = 6
) (
  input  logic [VAL_W-1:0] a,
  input  logic [VAL_W-1:0] b,
  input  op_t              op,
  input  logic [RES_W-1:0] target,
  output logic [RES_W-1:0] res,
  output logic             match
);

  logic [RES_W-1:0] ext_a;
  logic [RES_W-1:0] ext_b;

  // Operands are unsigned; zero-extend so a subtraction wraps into a signed two's complement result.
  always_comb begin
    ext_a = RES_W'(a);
    ext_b = RES_W'(b);
    res   = (op == OP_SUB) ? (ext_a - ext_b) : (ext_a + ext_b);
    match = (res == target);
  end

endmodule

// File: rtl/math_hit_processor.sv
// Collision consumer: assembles "A op B" from hit pulses, scores it, and runs lives/respawn/game-over.
// Pulse semantics: every input pulse is sampled on the clock edge it is high for, and every output
// pulse (numberConsumed, respawnMonkey, roundWin) is high for exactly one cycle, with no back-pressure.
module math_hit_processor
  import math_hit_processor_pkg::*;
#(
  parameter int NUMBERS        = 3,
  parameter int VAL_W          = 4,
  parameter int RES_W          = 6,
  parameter int SCORE_W        = 8,
  parameter int LIVES          = 3,
  parameter int POINTS         = 10,
  parameter int RESPAWN_FRAMES = 2,
  parameter int LIVES_W        = $clog2(LIVES + 1)
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic                     startGame,
  input  logic [NUMBERS-1:0]       SingleHitPulse,
  input  logic [1:0]               operandHit,
  input  logic                     waterCollision,
  input  logic [NUMBERS*VAL_W-1:0] numberValues,
  input  logic [RES_W-1:0]         targetValue,
  output logic [NUMBERS-1:0]       numberConsumed,
  output logic                     respawnMonkey,
  output logic                     roundWin,
  output logic                     gameOver,
  output logic [SCORE_W-1:0]       score,
  output logic [LIVES_W-1:0]       lives,
  output logic [2:0]               state
);

  localparam int FRAME_W = $clog2(RESPAWN_FRAMES + 1);

  state_t               state_q, state_d;
  logic [VAL_W-1:0]     a_q, a_d, b_q, b_d;
  op_t                  op_q, op_d;
  logic                 water_q, water_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [NUMBERS-1:0]   consumed_q, consumed_d;
  logic                 respawn_q, respawn_d;
  logic                 win_q, win_d;
  logic                 game_over_q, game_over_d;

  logic [NUMBERS-1:0]   hit_onehot;
  logic [VAL_W-1:0]     hit_val;
  logic [RES_W-1:0]     alu_res;
  logic                 alu_match;
  logic [SCORE_W:0]     score_sum;
  logic                 in_play;
  logic                 death;

  expr_alu #(.VAL_W(VAL_W), .RES_W(RES_W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .target (targetValue),
    .res    (alu_res),
    .match  (alu_match)
  );

  // Pick the lowest-index number hit this cycle and fetch its value.
  always_comb begin
    hit_onehot = NUMBERS'(lowest_set_onehot(32'(SingleHitPulse)));
    hit_val    = '0;
    for (int i = 0; i < NUMBERS; i++) begin
      if (hit_onehot[i]) hit_val = numberValues[i*VAL_W +: VAL_W];
    end
  end

  // Next-state and next-output logic; a water death in a frame overrides everything else that cycle.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    water_d     = water_q;
    frame_d     = frame_q;
    score_d     = score_q;
    lives_d     = lives_q;
    consumed_d  = '0;
    respawn_d   = 1'b0;
    win_d       = 1'b0;
    score_sum   = {1'b0, score_q} + (SCORE_W+1)'(POINTS);
    in_play     = (state_q == ST_WAIT_A) || (state_q == ST_WAIT_OP) ||
                  (state_q == ST_WAIT_B) || (state_q == ST_EVAL);
    death       = in_play && water_q && startOfFrame;

    if (in_play && waterCollision) water_d = 1'b1;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (startGame) begin
          state_d = ST_WAIT_A;
          score_d = '0;
          lives_d = LIVES_W'(LIVES);
          water_d = 1'b0;
        end
      end
      ST_WAIT_A: begin
        if (|SingleHitPulse) begin
          a_d        = hit_val;
          consumed_d = hit_onehot;
          state_d    = ST_WAIT_OP;
        end
      end
      ST_WAIT_OP: begin
        if (operandHit[0]) begin
          op_d    = OP_ADD;
          state_d = ST_WAIT_B;
        end else if (operandHit[1]) begin
          op_d    = OP_SUB;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (|SingleHitPulse) begin
          b_d        = hit_val;
          consumed_d = hit_onehot;
          state_d    = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (alu_match) begin
          score_d = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
          win_d   = 1'b1;
        end
        state_d = ST_WAIT_A;
      end
      ST_RESPAWN: begin
        if (startOfFrame) begin
          if (frame_q <= FRAME_W'(1)) begin
            frame_d = '0;
            state_d = ST_WAIT_A;
          end else begin
            frame_d = frame_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (death) begin
      a_d        = '0;
      b_d        = '0;
      op_d       = OP_ADD;
      water_d    = 1'b0;
      score_d    = score_q;
      consumed_d = '0;
      win_d      = 1'b0;
      if (lives_q <= LIVES_W'(1)) begin
        lives_d = '0;
        state_d = ST_GAME_OVER;
      end else begin
        lives_d   = lives_q - 1'b1;
        respawn_d = 1'b1;
        frame_d   = FRAME_W'(RESPAWN_FRAMES);
        state_d   = ST_RESPAWN;
      end
    end

    game_over_d = (state_d == ST_GAME_OVER);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      water_q     <= 1'b0;
      frame_q     <= '0;
      score_q     <= '0;
      lives_q     <= '0;
      consumed_q  <= '0;
      respawn_q   <= 1'b0;
      win_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      water_q     <= water_d;
      frame_q     <= frame_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      consumed_q  <= consumed_d;
      respawn_q   <= respawn_d;
      win_q       <= win_d;
      game_over_q <= game_over_d;
    end
  end

  assign numberConsumed = consumed_q;
  assign respawnMonkey  = respawn_q;
  assign roundWin       = win_q;
  assign gameOver       = game_over_q;
  assign score          = score_q;
  assign lives          = lives_q;
  assign state          = state_q;

endmodule
